// File: rtl/pulse_train_generator.sv
// Programmable pulse train generator: on trigger, emits N pulses of W cycles high, spaced P cycles apart.
// Width/period/count take effect per train via shadow copies latched when the trigger is accepted.
module pulse_train_generator #(
    parameter int MAX_PERIOD  = 1000000,
    parameter int TIME_WIDTH  = $clog2(MAX_PERIOD) + 1,
    parameter int MAX_PULSES  = 256,
    parameter int COUNT_WIDTH = $clog2(MAX_PULSES) + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [TIME_WIDTH-1:0]  width_value,
    input  logic                   width_set,
    input  logic [TIME_WIDTH-1:0]  period_value,
    input  logic                   period_set,
    input  logic [COUNT_WIDTH-1:0] count_value,
    input  logic                   count_set,
    input  logic                   trigger,
    input  logic                   overrun_clear,
    output logic                   pulse_out,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    localparam logic [TIME_WIDTH-1:0]  ONE_T = TIME_WIDTH'(1);
    localparam logic [TIME_WIDTH-1:0]  TWO_T = TIME_WIDTH'(2);
    localparam logic [COUNT_WIDTH-1:0] ONE_C = COUNT_WIDTH'(1);

    state_t                 state, state_nxt;

    logic [TIME_WIDTH-1:0]  width_reg, period_reg;
    logic [COUNT_WIDTH-1:0] count_reg;

    logic [TIME_WIDTH-1:0]  w_shadow, w_shadow_nxt;
    logic [TIME_WIDTH-1:0]  p_shadow, p_shadow_nxt;
    logic [COUNT_WIDTH-1:0] n_shadow, n_shadow_nxt;

    logic [TIME_WIDTH-1:0]  phase, phase_nxt;
    logic [COUNT_WIDTH-1:0] pulse_cnt, pulse_cnt_nxt;

    logic                   pulse_nxt, busy_nxt, done_nxt, overrun_nxt;
    logic [TIME_WIDTH-1:0]  w_eff, p_eff;

    // Clamped values are only ever written into the shadows; the config regs keep what was written.
    always_comb begin
        w_eff = (width_reg == '0) ? ONE_T : width_reg;
        p_eff = (period_reg > w_eff) ? period_reg : (w_eff + ONE_T);
    end

    always_comb begin
        state_nxt     = state;
        w_shadow_nxt  = w_shadow;
        p_shadow_nxt  = p_shadow;
        n_shadow_nxt  = n_shadow;
        phase_nxt     = phase;
        pulse_cnt_nxt = pulse_cnt;
        done_nxt      = 1'b0;
        overrun_nxt   = overrun;

        case (state)
            S_IDLE: begin
                if (trigger && (count_reg != '0)) begin
                    state_nxt     = S_HIGH;
                    w_shadow_nxt  = w_eff;
                    p_shadow_nxt  = p_eff;
                    n_shadow_nxt  = count_reg;
                    phase_nxt     = ONE_T;
                    pulse_cnt_nxt = ONE_C;
                end
            end
            S_HIGH: begin
                if (phase == w_shadow) begin
                    if (pulse_cnt == n_shadow) begin
                        state_nxt     = S_IDLE;
                        done_nxt      = 1'b1;
                        phase_nxt     = '0;
                        pulse_cnt_nxt = '0;
                    end else begin
                        state_nxt = S_LOW;
                        phase_nxt = phase + ONE_T;
                    end
                end else begin
                    phase_nxt = phase + ONE_T;
                end
            end
            S_LOW: begin
                if (phase == p_shadow) begin
                    state_nxt     = S_HIGH;
                    phase_nxt     = ONE_T;
                    pulse_cnt_nxt = pulse_cnt + ONE_C;
                end else begin
                    phase_nxt = phase + ONE_T;
                end
            end
            default: begin
                state_nxt     = S_IDLE;
                phase_nxt     = '0;
                pulse_cnt_nxt = '0;
            end
        endcase

        // Disable overrides every state transition, including a pending done.
        if (!enable) begin
            state_nxt     = S_IDLE;
            phase_nxt     = '0;
            pulse_cnt_nxt = '0;
            done_nxt      = 1'b0;
        end

        // Set has priority over clear when both land in the same cycle.
        if (overrun_clear) begin
            overrun_nxt = 1'b0;
        end
        if (trigger && enable && (state != S_IDLE)) begin
            overrun_nxt = 1'b1;
        end

        pulse_nxt = (state_nxt == S_HIGH);
        busy_nxt  = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            width_reg  <= ONE_T;
            period_reg <= TWO_T;
            count_reg  <= ONE_C;
            w_shadow   <= ONE_T;
            p_shadow   <= TWO_T;
            n_shadow   <= ONE_C;
            phase      <= '0;
            pulse_cnt  <= '0;
            pulse_out  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state     <= state_nxt;
            w_shadow  <= w_shadow_nxt;
            p_shadow  <= p_shadow_nxt;
            n_shadow  <= n_shadow_nxt;
            phase     <= phase_nxt;
            pulse_cnt <= pulse_cnt_nxt;
            pulse_out <= pulse_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            overrun   <= overrun_nxt;
            if (width_set) begin
                width_reg <= width_value;
            end
            if (period_set) begin
                period_reg <= period_value;
            end
            if (count_set) begin
                count_reg <= count_value;
            end
        end
    end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator: per-cycle expected output patterns, computed by hand.
module tb_pulse_train_generator;

    localparam int TW = 21;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [TW-1:0] width_value;
    logic          width_set;
    logic [TW-1:0] period_value;
    logic          period_set;
    logic [CW-1:0] count_value;
    logic          count_set;
    logic          trigger;
    logic          overrun_clear;
    logic          pulse_out;
    logic          busy;
    logic          done;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    pulse_train_generator dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .width_value   (width_value),
        .width_set     (width_set),
        .period_value  (period_value),
        .period_set    (period_set),
        .count_value   (count_value),
        .count_set     (count_set),
        .trigger       (trigger),
        .overrun_clear (overrun_clear),
        .pulse_out     (pulse_out),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed %b expected %b", tag, idx, obs, exp);
        end
    endtask

    task automatic program_cfg(input int w, input int p, input int n);
        width_value  = TW'(w);
        period_value = TW'(p);
        count_value  = CW'(n);
        width_set    = 1'b1;
        period_set   = 1'b1;
        count_set    = 1'b1;
        tick();
        width_set    = 1'b0;
        period_set   = 1'b0;
        count_set    = 1'b0;
    endtask

    // Cycle i of a run: drive bit i of each stimulus pattern, check bit i of each expected pattern
    // against the registered outputs present in that cycle, then advance one clock.
    task automatic run_seq(input string tag, input int n,
                           input logic [31:0] trg, input logic [31:0] ovc, input logic [31:0] dis,
                           input logic [31:0] wset, input logic [31:0] cset,
                           input logic [31:0] e_pulse, input logic [31:0] e_busy,
                           input logic [31:0] e_done, input logic [31:0] e_ovr);
        for (int i = 0; i < n; i++) begin
            trigger       = trg[i];
            overrun_clear = ovc[i];
            enable        = ~dis[i];
            width_set     = wset[i];
            count_set     = cset[i];
            chk({tag, ".pulse"},   i, pulse_out, e_pulse[i]);
            chk({tag, ".busy"},    i, busy,      e_busy[i]);
            chk({tag, ".done"},    i, done,      e_done[i]);
            chk({tag, ".overrun"}, i, overrun,   e_ovr[i]);
            tick();
        end
        trigger       = 1'b0;
        overrun_clear = 1'b0;
        enable        = 1'b1;
        width_set     = 1'b0;
        count_set     = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b1;
        width_value   = '0;
        width_set     = 1'b0;
        period_value  = '0;
        period_set    = 1'b0;
        count_value   = '0;
        count_set     = 1'b0;
        trigger       = 1'b0;
        overrun_clear = 1'b0;
        tick();
        tick();
        chk("reset.pulse",   0, pulse_out, 1'b0);
        chk("reset.busy",    0, busy,      1'b0);
        chk("reset.done",    0, done,      1'b0);
        chk("reset.overrun", 0, overrun,   1'b0);
        reset_n = 1'b1;
        tick();

        // W=3 P=5 N=2: high 1-3 and 6-8, done at 9
        program_cfg(3, 5, 2);
        run_seq("t1", 11, 32'h1, 0, 0, 0, 0, 32'h1CE, 32'h1FE, 32'h200, 0);

        // W=0 P=0 N=3 clamps to W=1 P=2: high 1,3,5, done at 6
        program_cfg(0, 0, 3);
        run_seq("t2", 8, 32'h1, 0, 0, 0, 0, 32'h2A, 32'h3E, 32'h40, 0);

        // Back-to-back: trigger in the done cycle is accepted without overrun
        program_cfg(1, 2, 1);
        run_seq("b2b", 5, 32'h5, 0, 0, 0, 0, 32'hA, 32'hA, 32'h14, 0);

        // W=2 P=4 N=4 with a second trigger and a clear at cycle 3: set wins, train unaffected
        program_cfg(2, 4, 4);
        run_seq("t3", 17, 32'h9, 32'h8, 0, 0, 0, 32'h6666, 32'h7FFE, 32'h8000, 32'h1FFF0);
        run_seq("t3clr", 2, 0, 32'h1, 0, 0, 0, 0, 0, 0, 32'h1);

        // Mid-train writes (W=5, N=1 at cycle 2) only affect the next train (P_eff then 6)
        program_cfg(2, 4, 3);
        width_value = TW'(5);
        count_value = CW'(1);
        run_seq("t4a", 12, 32'h1, 0, 0, 32'h4, 32'h4, 32'h666, 32'h7FE, 32'h800, 0);
        run_seq("t4b", 7, 32'h1, 0, 0, 0, 0, 32'h3E, 32'h3E, 32'h40, 0);

        // Disable at cycle 4 (in LOW) for three cycles; triggers with enable low do nothing
        program_cfg(3, 5, 2);
        run_seq("t5", 10, 32'h51, 0, 32'h70, 0, 0, 32'hE, 32'h1E, 0, 0);

        // Zero count: trigger is a no-op
        program_cfg(3, 5, 0);
        run_seq("t6cnt0", 4, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-HIGH with overrun set
        program_cfg(3, 5, 2);
        trigger = 1'b1;
        tick();
        chk("t6rst.pulse_c1", 1, pulse_out, 1'b1);
        tick();
        trigger = 1'b0;
        reset_n = 1'b0;
        chk("t6rst.overrun_c2", 2, overrun,   1'b1);
        chk("t6rst.pulse_c2",   2, pulse_out, 1'b1);
        tick();
        reset_n = 1'b1;
        chk("t6rst.pulse",   3, pulse_out, 1'b0);
        chk("t6rst.busy",    3, busy,      1'b0);
        chk("t6rst.done",    3, done,      1'b0);
        chk("t6rst.overrun", 3, overrun,   1'b0);
        tick();

        // Config regs back to W=1 P=2 N=1: single 1-cycle pulse
        run_seq("t6def", 4, 32'h1, 0, 0, 0, 0, 32'h2, 32'h2, 32'h4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
